// File: rtl/am_agc_ctrl.sv
// rtl/am_agc_ctrl.sv - AM rectifier/scaler with windowed peak-envelope gain control
//
// Purpose:
//   Full-wave rectifies signed AM samples (with saturation) and scales them by
//   2^gain_shift before forwarding to the demod low-pass FIR. A window FSM
//   measures the peak of the scaled magnitude over WIN_LEN valid samples. At
//   the end of each window it nudges gain_shift so the FIR input sits between
//   LO_TH and HI_TH.
//
// Ports:
//   clk          in   1    system clock
//   rst_n        in   1    asynchronous active-low reset
//   enable       in   1    1 = run AGC loop; 0 = freeze gain, FSM to IDLE
//   sample_valid in   1    sample_in valid this cycle
//   sample_in    in   DW   signed AM sample
//   rect_valid   out  1    rect_data valid (to FIR)
//   rect_data    out  DW   scaled, saturated magnitude (MSB always 0)
//   gain_shift   out  3    current gain exponent
//   peak_last    out  DW   peak of last completed window
//   locked       out  1    gain stable for LOCK_WINS windows

module am_agc_ctrl #(
  parameter int DW         = 16,
  parameter int WIN_LEN    = 1024,
  parameter int HI_TH      = 28000,
  parameter int LO_TH      = 12000,
  parameter int MAX_SHIFT  = 4,
  parameter int INIT_SHIFT = 0,
  parameter int LOCK_WINS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic          rect_valid,
  output logic [DW-1:0] rect_data,
  output logic [2:0]    gain_shift,
  output logic [DW-1:0] peak_last,
  output logic          locked
);

  // Shifted magnitude is kept 7 bits wider than a sample so no shift by a
  // 3-bit exponent can wrap before the saturation compare.
  localparam int SW = DW + 7;
  localparam int CW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int IW = $clog2(LOCK_WINS + 1) > 0 ? $clog2(LOCK_WINS + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(WIN_LEN - 1);
  localparam logic [DW-1:0] HI_LIM    = DW'(HI_TH);
  localparam logic [DW-1:0] LO_LIM    = DW'(LO_TH);
  localparam logic [2:0]    MAX_G     = 3'(MAX_SHIFT);
  localparam logic [2:0]    INIT_G    = 3'(INIT_SHIFT);
  localparam logic [IW-1:0] LOCK_N    = IW'(LOCK_WINS);
  localparam logic [DW-1:0] POS_MAX   = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] peak;
  logic [IW-1:0] inband_cnt;

  // ------------------------------------------------------------------
  // Rectify and scale (combinational, uses the gain currently in force)
  // ------------------------------------------------------------------
  logic [DW-1:0] neg_val;
  logic [DW-1:0] abs_full;
  logic [DW-2:0] mag;
  logic [SW-1:0] shifted;
  logic [DW-1:0] scaled;

  always_comb begin
    neg_val  = ~sample_in + 1'b1;
    abs_full = sample_in[DW-1] ? neg_val : sample_in;
    // Only the most negative input still has its MSB set after negation.
    mag      = abs_full[DW-1] ? {(DW-1){1'b1}} : abs_full[DW-2:0];
    shifted  = {8'b0, mag} << gain_shift;
    if (|shifted[SW-1:DW-1]) begin
      scaled = POS_MAX;
    end else begin
      scaled = shifted[DW-1:0];
    end
  end

  // ------------------------------------------------------------------
  // Window-end decision terms
  // ------------------------------------------------------------------
  logic          go_down;
  logic          go_up;
  logic [IW-1:0] inband_inc;

  always_comb begin
    go_down    = (peak > HI_LIM) && (gain_shift != 3'd0);
    go_up      = (peak < LO_LIM) && (gain_shift < MAX_G);
    inband_inc = (inband_cnt >= LOCK_N) ? inband_cnt : inband_cnt + 1'b1;
  end

  // ------------------------------------------------------------------
  // Datapath registers and window FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rect_valid <= 1'b0;
      rect_data  <= '0;
      gain_shift <= INIT_G;
      peak_last  <= '0;
      locked     <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      peak       <= '0;
      inband_cnt <= '0;
    end else begin
      // The FIR feed runs independently of the AGC loop.
      rect_valid <= sample_valid;
      if (sample_valid) begin
        rect_data <= scaled;
      end

      case (state)
        IDLE: begin
          cnt  <= '0;
          peak <= '0;
          if (enable) begin
            state <= MEASURE;
          end
        end

        MEASURE: begin
          if (!enable) begin
            // Partial window is thrown away; gain and lock status hold.
            state <= IDLE;
            cnt   <= '0;
            peak  <= '0;
          end else if (sample_valid) begin
            if (scaled > peak) begin
              peak <= scaled;
            end
            if (cnt == CNT_LAST) begin
              state <= UPDATE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        UPDATE: begin
          peak_last <= peak;
          if (go_down) begin
            gain_shift <= gain_shift - 3'd1;
            inband_cnt <= '0;
            locked     <= 1'b0;
          end else if (go_up) begin
            gain_shift <= gain_shift + 3'd1;
            inband_cnt <= '0;
            locked     <= 1'b0;
          end else begin
            inband_cnt <= inband_inc;
            locked     <= (inband_inc >= LOCK_N);
          end

          // A sample arriving now opens the next window, scaled with the
          // gain that was in force before this update.
          if (enable) begin
            state <= MEASURE;
            if (sample_valid) begin
              cnt  <= CW'(1);
              peak <= scaled;
            end else begin
              cnt  <= '0;
              peak <= '0;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
            peak  <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          peak  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_am_agc_ctrl.sv
// tb/tb_am_agc_ctrl.sv - scoreboard bench for am_agc_ctrl
module tb_am_agc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        rect_valid;
  logic [15:0] rect_data;
  logic [2:0]  gain_shift;
  logic [15:0] peak_last;
  logic        locked;

  logic        enable_b = 1'b0;
  logic        sample_valid_b = 1'b0;
  logic [15:0] sample_in_b = '0;
  logic        rect_valid_b;
  logic [15:0] rect_data_b;
  logic [2:0]  gain_shift_b;
  logic [15:0] peak_last_b;
  logic        locked_b;

  always #5 clk = ~clk;

  am_agc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .rect_valid(rect_valid), .rect_data(rect_data),
    .gain_shift(gain_shift), .peak_last(peak_last), .locked(locked)
  );

  am_agc_ctrl #(.INIT_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b),
    .sample_valid(sample_valid_b), .sample_in(sample_in_b),
    .rect_valid(rect_valid_b), .rect_data(rect_data_b),
    .gain_shift(gain_shift_b), .peak_last(peak_last_b), .locked(locked_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // scoreboard of expected rect_data values
  int sb[$];

  // reference model of the main DUT
  int m_state = 0;   // 0 idle, 1 measure, 2 update
  int m_cnt = 0, m_pk = 0, m_gain = 0, m_pl = 0, m_ib = 0, m_lk = 0, m_rv = 0;
  int win_idx = 0;
  bit win_done = 0;
  bit tbl_on = 0;
  int t_gain[7] = '{1, 2, 3, 3, 3, 3, 3};
  int t_peak[7] = '{2000, 4000, 8000, 16000, 16000, 16000, 16000};
  int t_lock[7] = '{0, 0, 0, 0, 0, 0, 1};

  always @(negedge clk) begin
    if (rst_n && rect_valid) begin
      if (sb.size() == 0) chk("rect_stray", 1, 0);
      else chk("rect_data", 32'(rect_data), sb.pop_front());
    end
  end

  task automatic step(input bit en, input bit v, input int x);
    int mg, sc;
    @(negedge clk);
    chk("rect_valid", 32'(rect_valid), m_rv);
    chk("gain_shift", 32'(gain_shift), m_gain);
    chk("peak_last", 32'(peak_last), m_pl);
    chk("locked", 32'(locked), m_lk);
    if (win_done && tbl_on && win_idx >= 1 && win_idx <= 7) begin
      chk("t3_gain", 32'(gain_shift), t_gain[win_idx-1]);
      chk("t3_peak", 32'(peak_last), t_peak[win_idx-1]);
      chk("t3_lock", 32'(locked), t_lock[win_idx-1]);
    end
    win_done = 0;
    enable = en;
    sample_valid = v;
    sample_in = 16'(x);
    mg = (x < 0) ? -x : x;
    if (mg > 32767) mg = 32767;
    sc = mg * (1 << m_gain);
    if (sc > 32767) sc = 32767;
    if (v) sb.push_back(sc);
    case (m_state)
      0: begin
        m_cnt = 0; m_pk = 0;
        if (en) m_state = 1;
      end
      1: begin
        if (!en) begin
          m_state = 0; m_cnt = 0; m_pk = 0;
        end else if (v) begin
          if (sc > m_pk) m_pk = sc;
          if (m_cnt == 1023) m_state = 2;
          else m_cnt++;
        end
      end
      default: begin
        m_pl = m_pk;
        win_done = 1;
        win_idx++;
        if (m_pk > 28000 && m_gain > 0) begin
          m_gain--; m_ib = 0;
        end else if (m_pk < 12000 && m_gain < 4) begin
          m_gain++; m_ib = 0;
        end else if (m_ib < 4) begin
          m_ib++;
        end
        m_lk = (m_ib >= 4) ? 1 : 0;
        if (en) begin
          m_state = 1; m_cnt = v ? 1 : 0; m_pk = v ? sc : 0;
        end else begin
          m_state = 0; m_cnt = 0; m_pk = 0;
        end
      end
    endcase
    m_rv = v ? 1 : 0;
  endtask

  initial begin
    // 1: reset held while samples arrive
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_rect_valid", 32'(rect_valid), 0);
      chk("rst_gain", 32'(gain_shift), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_peak_last", 32'(peak_last), 0);
      sample_valid = 1'b1;
      sample_in = 16'd100;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    rst_n = 1'b1;

    // 2: saturation at gain 0, loop disabled
    step(0, 0, 0);
    step(0, 1, -32768);
    step(0, 1, -5);
    step(0, 1, 7);
    step(0, 1, 32767);
    step(0, 0, 0);
    step(0, 0, 0);

    // 3: gain walks up on |x|=2000 until locked
    step(1, 0, 0);
    tbl_on = 1;
    for (int i = 0; i < 9000 && win_idx < 7; i++) begin
      step(1, 1, (i % 2) ? -2000 : 2000);
    end
    if (win_idx < 7) chk("t3_timeout", win_idx, 7);
    step(1, 1, 2000);
    tbl_on = 0;

    // 6: drop enable at cnt=500
    for (int i = 0; i < 498; i++) step(1, 1, (i % 2) ? 2000 : -2000);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_gain_hold", 32'(gain_shift), 3);
    chk("t6_lock_hold", 32'(locked), 1);
    // 2 (cont.): gain 3 saturation while frozen
    step(0, 1, 5000);
    step(0, 1, -32768);
    step(0, 0, 0);
    // re-enable: fresh window of 1024 samples
    step(1, 0, 0);
    for (int i = 0; i < 1024; i++) step(1, 1, (i % 2) ? -3000 : 3000);
    step(1, 0, 0);
    chk("t6_not_yet", 32'(peak_last), 16000);
    step(1, 0, 0);
    chk("t6_fresh_peak", 32'(peak_last), 24000);
    chk("t6_gain", 32'(gain_shift), 3);

    // 5: sparse samples, sample during UPDATE uses old gain
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step(1, 0, 0);
      step(1, 1, (i % 2) ? -1000 : 1000);
    end
    step(1, 1, 1000);
    step(1, 0, 0);
    chk("t5_old_gain_rect", 32'(rect_data), 8000);
    chk("t5_gain_up", 32'(gain_shift), 4);
    chk("t5_peak", 32'(peak_last), 8000);
    for (int i = 0; i < 1023; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) step(1, 0, 0);
      step(1, 1, (i % 2) ? -2000 : 2000);
    end
    step(1, 0, 0);
    chk("t5_boundary_hold", 32'(gain_shift), 4);
    step(1, 0, 0);
    chk("t5_gain_down", 32'(gain_shift), 3);
    chk("t5_peak2", 32'(peak_last), 32000);
    chk("t5_lock", 32'(locked), 0);

    // asynchronous reset mid-window
    step(1, 1, 500);
    step(1, 1, 500);
    step(1, 0, 0);
    #3;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst_gain", 32'(gain_shift), 0);
    chk("arst_peak_last", 32'(peak_last), 0);
    chk("arst_rect_valid", 32'(rect_valid), 0);
    chk("arst_rect_data", 32'(rect_data), 0);
    chk("arst_sb_empty", sb.size(), 0);
    sb.delete();
    m_state = 0; m_cnt = 0; m_pk = 0; m_gain = 0; m_pl = 0; m_ib = 0; m_lk = 0; m_rv = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // 4: gain down on second instance (INIT_SHIFT=2)
    @(negedge clk);
    chk("t4_init_gain", 32'(gain_shift_b), 2);
    enable_b = 1'b1;
    sample_valid_b = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (i == 1) chk("t4_rect_sat", 32'(rect_data_b), 32767);
      sample_valid_b = 1'b1;
      sample_in_b = (i % 2) ? -16'sd10000 : 16'sd10000;
    end
    @(negedge clk);
    sample_valid_b = 1'b0;
    chk("t4_pre_update", 32'(gain_shift_b), 2);
    @(negedge clk);
    chk("t4_gain1", 32'(gain_shift_b), 1);
    chk("t4_peak1", 32'(peak_last_b), 32767);
    chk("t4_lock1", 32'(locked_b), 0);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      sample_valid_b = 1'b1;
      sample_in_b = 16'sd10000;
    end
    @(negedge clk);
    sample_valid_b = 1'b0;
    @(negedge clk);
    chk("t4_gain2", 32'(gain_shift_b), 1);
    chk("t4_peak2", 32'(peak_last_b), 20000);
    chk("t4_lock2", 32'(locked_b), 0);
    enable_b = 1'b0;

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
